seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised Moore-style serial pattern detector, the successor to the fixed 1011 detector. It samples one serial bit per qualified clock and compares it against a runtime-loadable pattern of 1..MAX_LEN bits. Overlapping or non-overlapping matching is selectable, and a saturating match counter is provided. It sits on the serial input path and feeds a registered match pulse and event count to downstream control logic.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- COUNT_WIDTH, 8: width of match_count.
- DEFAULT_PATTERN, 8'b0000_1011: pattern loaded at reset, right-aligned, MAX_LEN bits.
- DEFAULT_LEN, 4: pattern length loaded at reset.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset. All registers clear immediately on assertion; release is synchronous to clock.
- sequence_in  in  1  serial data bit.
- in_valid  in  1  sequence_in is sampled only when this is high.
- cfg_load  in  1  one-cycle strobe that latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned. Bit [len-1] is the first bit received; bit [0] is the last.
- cfg_len  in  $clog2(MAX_LEN+1)  new pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- count_clear  in  1  synchronous clear of match_count.
- detector_out  out  1  registered match pulse.
- match_count  out  COUNT_WIDTH  saturating count of matches.

## Operation
- **Internal state:**
  - active pattern, length and overlap registers;
  - MAX_LEN-bit history shift register, newest bit in [0];
  - fill counter, range 0..MAX_LEN, saturating.
- **Reset state:**
  - pattern = DEFAULT_PATTERN, len = DEFAULT_LEN, overlap = 1;
  - history = 0, fill = 0;
  - detector_out = 0, match_count = 0.
- **Sample step** (in_valid=1, cfg_load=0):
  - history shifts left with sequence_in entering at [0];
  - fill increments, saturating at MAX_LEN.
- **Match condition**, evaluated on the post-shift history: fill ≥ len and history[len-1:0] == pattern[len-1:0].
- **On a match:**
  - detector_out = 1 for the following cycle only;
  - match_count increments;
  - if overlap = 0, fill resets to 0, so the next match needs len fresh bits;
  - if overlap = 1, fill is untouched.
- **Pulse behaviour:** detector_out returns to 0 at the next edge unless that edge also produces a match. It never holds high across in_valid=0 cycles.
- **in_valid=0:** history, fill and the count are unchanged; detector_out is 0 after that edge.
- **cfg_load=1:**
  - latches the new configuration;
  - clears history and fill;
  - takes priority over in_valid, so the bit in that cycle is discarded;
  - forces detector_out to 0;
  - leaves match_count unchanged.
- **Length rules:**
  - cfg_len = 0 disables matching: detector_out stays 0 and the count is frozen;
  - cfg_len > MAX_LEN is clamped to MAX_LEN;
  - pattern bits above len are ignored.
- **match_count:**
  - saturates at 2^COUNT_WIDTH−1;
  - count_clear sets it to 0 and wins over a simultaneous match; that match is not counted but detector_out still pulses.
- **Conceptual FSM states:** IDLE (fill=0), FILLING (0<fill<len), ARMED (fill≥len, no match), MATCH (detector_out=1). MATCH returns to ARMED when overlap=1, or to IDLE when overlap=0.

## Timing
- **Latency:** the completing bit is sampled at edge k; detector_out is high from edge k to edge k+1; match_count shows the new value from edge k.
- **Throughput:** one bit per clock; back-to-back matches are possible every clock when overlap=1 and len=1.
- **Configuration:** a cfg_load at edge k takes effect for bits sampled at edge k+1 onward.
- **Reset mid-operation:** all outputs drop to their reset values asynchronously. The first valid sample after release starts a fresh history.

## Test plan
- **Default 1011, overlapping:** after reset, valid stream 1,0,1,1,0,1,1 → detector_out pulses after the 4th and 7th bits; match_count = 2.
- **Non-overlap vs overlap:** cfg_pattern=2'b11, cfg_len=2, stream of seven 1s.
  - cfg_overlap=1 → six pulses, count = 6.
  - cfg_overlap=0 → pulses after bits 2, 4 and 6, count = 3.
- **in_valid gaps:** 1011 with in_valid=0 for 3 cycles between each bit → exactly one pulse, one cycle wide, after the final valid bit; no pulse during the gaps.
- **Saturation and clear:** COUNT_WIDTH=2, five matches → count = 3. count_clear coincident with a 6th match → count = 0 while detector_out still pulses.
- **Reset mid-pattern:** drive 1,0,1, pulse reset low between edges, then drive 1 → no pulse. A full 1,0,1,1 afterwards → one pulse.
- **Config edges:**
  - cfg_len = 0 → no pulse on any stream;
  - cfg_len = MAX_LEN+3 behaves as MAX_LEN;
  - cfg_load in the same cycle as an in_valid bit → that bit is ignored.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector. The pattern (1..MAX_LEN bits) and the overlap mode can be
// loaded at runtime. Produces a registered match pulse and a saturating match count.
module seq_detector_param #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned COUNT_WIDTH = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int unsigned DEFAULT_LEN = 4,
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sequence_in,
    input  logic                   in_valid,
    input  logic                   cfg_load,
    input  logic [MAX_LEN-1:0]     cfg_pattern,
    input  logic [LEN_W-1:0]       cfg_len,
    input  logic                   cfg_overlap,
    input  logic                   count_clear,
    output logic                   detector_out,
    output logic [COUNT_WIDTH-1:0] match_count
);

    localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DefLen  = (DEFAULT_LEN > MAX_LEN) ? MaxLenW
                                                                   : LEN_W'(DEFAULT_LEN);

    typedef enum logic [1:0] {StIdle, StFilling, StArmed, StMatch} state_e;

    state_e                 state_q, state_d;
    logic [MAX_LEN-1:0]     pattern_q, pattern_d;
    logic [MAX_LEN-1:0]     history_q, history_d;
    logic [MAX_LEN-1:0]     shifted, len_mask;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       fill_q, fill_d, fill_inc;
    logic                   overlap_q, overlap_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   match;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            pattern_q <= DEFAULT_PATTERN;
            len_q     <= DefLen;
            overlap_q <= 1'b1;
            history_q <= '0;
            fill_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
        end
    end

    // Only the low len bits of the history and the pattern take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end
    end

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        history_d = history_q;
        fill_d    = fill_q;
        match     = 1'b0;
        shifted   = {history_q[MAX_LEN-2:0], sequence_in};
        fill_inc  = (fill_q == MaxLenW) ? fill_q : fill_q + 1'b1;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = (cfg_len > MaxLenW) ? MaxLenW : cfg_len;
            overlap_d = cfg_overlap;
            history_d = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            history_d = shifted;
            fill_d    = fill_inc;
            match     = (len_q != '0) && (fill_inc >= len_q) &&
                        ((shifted & len_mask) == (pattern_q & len_mask));
            // Non-overlapping mode needs len fresh bits before the next match.
            if (match && !overlap_q) begin
                fill_d = '0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (count_clear) begin
            count_d = '0;
        end else if (match && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_comb begin
        if (match) begin
            state_d = StMatch;
        end else if (fill_d == '0) begin
            state_d = StIdle;
        end else if (fill_d < len_d) begin
            state_d = StFilling;
        end else begin
            state_d = StArmed;
        end
    end

    always_comb begin
        detector_out = 1'b0;
        unique case (state_q)
            StMatch: detector_out = 1'b1;
            default: detector_out = 1'b0;
        endcase
    end

    assign match_count = count_q;

endmodule
